register_slice: RTL and testbench

REGISTER_SLICE -- requirements
Module: register_slice

---
 rtl/register_slice.sv | 105 ++++++++++
 tb/tb_register_slice.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/register_slice.sv
// register_slice: two-entry valid/ready pipeline stage (main + skid register).
// Every output comes straight from a flop, so no input reaches an output
// combinationally. Holding a second entry lets s_ready be registered while
// still sustaining one transfer per cycle.
module register_slice #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [1:0]       count
);

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic             s_ready_q, s_ready_d;
    logic             m_valid_q, m_valid_d;
    logic [1:0]       count_q, count_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             accept;

    // Upstream data is only taken when the registered ready was high.
    assign accept = s_valid && s_ready_q;

    // Next-state, register-load and registered-output decode.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    main_d  = s_data;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (accept && m_ready) begin
                    // Drain and refill on the same edge: no bubble.
                    main_d = s_data;
                end else if (accept) begin
                    skid_d  = s_data;
                    state_d = FULL;
                end else if (m_ready) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (m_ready) begin
                    main_d  = skid_q;
                    state_d = BUSY;
                end
            end
            default: begin
                // Illegal encoding recovers to EMPTY.
                state_d = EMPTY;
            end
        endcase

        // Outputs are precomputed from the next state so they can be flopped.
        s_ready_d = (state_d != FULL);
        m_valid_d = (state_d != EMPTY);
        case (state_d)
            BUSY:    count_d = 2'd1;
            FULL:    count_d = 2'd2;
            default: count_d = 2'd0;
        endcase
    end

    // State, data and output registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= EMPTY;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            count_q   <= 2'd0;
            main_q    <= '0;
            skid_q    <= '0;
        end else begin
            state_q   <= state_d;
            s_ready_q <= s_ready_d;
            m_valid_q <= m_valid_d;
            count_q   <= count_d;
            main_q    <= main_d;
            skid_q    <= skid_d;
        end
    end

    assign s_ready = s_ready_q;
    assign m_valid = m_valid_q;
    assign m_data  = main_q;
    assign count   = count_q;

endmodule

// File: tb/tb_register_slice.sv
// Testbench for register_slice (WIDTH=8): directed vector table, hand-written
// corner sequences and a randomized run against a queue model.
module tb_register_slice;

    logic       clk;
    logic       rst;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic [1:0] count;

    int checks;
    int failures;

    register_slice #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       sv;
        logic [7:0] sd;
        logic       mr;
        logic       exp_sr;
        logic       exp_mv;
        logic [7:0] exp_md;
        logic [1:0] exp_cnt;
    } vec_t;

    vec_t vecs [13];

    task automatic check_outputs(input string name, input logic e_sr, input logic e_mv,
                                 input logic [7:0] e_md, input logic [1:0] e_cnt);
        checks++;
        if (s_ready !== e_sr || m_valid !== e_mv || m_data !== e_md || count !== e_cnt) begin
            failures++;
            $display("FAIL %s: got sr=%b mv=%b md=%02h cnt=%0d, want sr=%b mv=%b md=%02h cnt=%0d",
                     name, s_ready, m_valid, m_data, count, e_sr, e_mv, e_md, e_cnt);
        end else begin
            $display("ok   %s: sr=%b mv=%b md=%02h cnt=%0d", name, s_ready, m_valid, m_data, count);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b0;
        s_data = 8'h00;
        #12;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Drive inputs, take one edge, then sample 1 time unit later.
    task automatic step(input logic sv, input logic [7:0] sd, input logic mr);
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        @(posedge clk);
        #1;
    endtask

    // Randomized model state
    logic [7:0] q [$];
    bit         rdy_en;

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        s_valid  = 1'b0;
        s_data   = 8'h00;
        m_ready  = 1'b0;

        //                sv  sd     mr   sr  mv  md     cnt
        vecs[0]  = '{1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0}; // first edge: no accept
        vecs[1]  = '{1'b1, 8'h11, 1'b1, 1'b1, 1'b1, 8'h11, 2'd1}; // accept in EMPTY
        vecs[2]  = '{1'b0, 8'h99, 1'b0, 1'b1, 1'b1, 8'h11, 2'd1}; // hold
        vecs[3]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5, 2'd1}; // accept+drain
        vecs[4]  = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 8'hA5, 2'd2}; // to FULL
        vecs[5]  = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 8'hA5, 2'd2}; // ignored
        vecs[6]  = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 8'hA5, 2'd2};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h5A, 2'd1}; // skid to main
        vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h5A, 2'd0}; // drain to EMPTY
        vecs[9]  = '{1'b0, 8'h33, 1'b0, 1'b1, 1'b0, 8'h5A, 2'd0}; // s_data ignored
        vecs[10] = '{1'b1, 8'h77, 1'b0, 1'b1, 1'b1, 8'h77, 2'd1};
        vecs[11] = '{1'b1, 8'h88, 1'b1, 1'b1, 1'b1, 8'h88, 2'd1};
        vecs[12] = '{1'b0, 8'h44, 1'b0, 1'b1, 1'b1, 8'h88, 2'd1};

        // Reset state while rst is high
        #3;
        check_outputs("reset_state", 1'b0, 1'b0, 8'h00, 2'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 13; i++) begin
            step(vecs[i].sv, vecs[i].sd, vecs[i].mr);
            check_outputs($sformatf("vec%0d", i), vecs[i].exp_sr, vecs[i].exp_mv,
                          vecs[i].exp_md, vecs[i].exp_cnt);
        end

        // Streaming 0x00..0xFF with m_ready held high
        do_reset();
        step(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 256; i++) begin
            step(1'b1, 8'(i), 1'b1);
            check_outputs($sformatf("stream%0d", i), 1'b1, 1'b1, 8'(i), 2'd1);
        end
        step(1'b0, 8'h00, 1'b1);
        check_outputs("stream_end", 1'b1, 1'b0, 8'hFF, 2'd0);

        // FULL with 0xFF offered for 5 cycles: never appears downstream
        do_reset();
        step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'hA5, 1'b0);
        step(1'b1, 8'h5A, 1'b0);
        check_outputs("full_entry", 1'b0, 1'b1, 8'hA5, 2'd2);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'hFF, 1'b0);
            check_outputs($sformatf("full_hold%0d", i), 1'b0, 1'b1, 8'hA5, 2'd2);
        end
        step(1'b0, 8'hFF, 1'b1);
        check_outputs("full_drain1", 1'b1, 1'b1, 8'h5A, 2'd1);
        step(1'b0, 8'hFF, 1'b1);
        check_outputs("full_drain2", 1'b1, 1'b0, 8'h5A, 2'd0);

        // Reset pulsed between edges while FULL
        do_reset();
        step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h21, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        check_outputs("prerst_full", 1'b0, 1'b1, 8'h21, 2'd2);
        s_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_outputs("midrst_async", 1'b0, 1'b0, 8'h00, 2'd0);
        #1;
        rst = 1'b0;
        step(1'b0, 8'h00, 1'b1);
        check_outputs("postrst_ready", 1'b1, 1'b0, 8'h00, 2'd0);
        step(1'b1, 8'h42, 1'b1);
        check_outputs("postrst_first", 1'b1, 1'b1, 8'h42, 2'd1);
        step(1'b0, 8'h00, 1'b1);
        check_outputs("postrst_empty", 1'b1, 1'b0, 8'h42, 2'd0);

        // Randomized traffic against a queue model
        do_reset();
        q.delete();
        rdy_en = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            logic       sv;
            logic       mr;
            logic [7:0] sd;
            logic       m_sr;
            logic       acc;
            logic       drn;
            logic [7:0] e_md;
            sv = 1'($urandom_range(0, 1));
            mr = 1'($urandom_range(0, 1));
            sd = 8'($urandom_range(0, 255));
            m_sr = rdy_en && (q.size() < 2);
            acc  = sv && m_sr;
            drn  = (q.size() > 0) && mr;
            s_valid = sv;
            s_data  = sd;
            m_ready = mr;
            @(posedge clk);
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(sd);
            rdy_en = 1'b1;
            #1;
            e_md = (q.size() > 0) ? q[0] : m_data;
            checks++;
            if (s_ready !== (q.size() < 2) || m_valid !== (q.size() > 0) ||
                count !== 2'(q.size()) || m_data !== e_md) begin
                failures++;
                $display("FAIL rand%0d: got sr=%b mv=%b md=%02h cnt=%0d, want sr=%b mv=%b md=%02h cnt=%0d",
                         c, s_ready, m_valid, m_data, count, (q.size() < 2), (q.size() > 0),
                         e_md, q.size());
            end
        end
        $display("random run: 10000 cycles compared");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
